pattern_gen: RTL
================

Name: pattern_gen

Overview:
Parametrised VGA test-pattern generator; next generation of the fixed 8-bar colour strip.
- Driven by the timing generator's `video_on` and `frame_start` strobes, not by `h_cnt` decode, so no comparator chain is needed.
- Supports four runtime-selectable modes, frame-synchronous mode switching, horizontal scrolling and registered outputs.
- Sits between the VGA timing generator and the pixel output mux.

Parameters:
- COLOR_W, 4, bits per colour channel.
- BAR_W, 80, bar width in pixels (≥2).
- BAR_H, 60, bar height in lines (≥1).
- NUM_BARS, 8, bars before index wraps (1..8).
- SCROLL_STEP, 1, pixels advanced per frame when scrolling (1..BAR_W-1).
- FRAME_DIV, 5, mode-3 colour changes every 2^FRAME_DIV frames.

Ports:
- clk, in, 1, pixel clock.
- rst, in, 1, synchronous active-high reset.
- video_on, in, 1, high during active pixels.
- frame_start, in, 1, one-cycle pulse per frame, normally in blanking.
- mode_sel, in, 2, requested mode.
- mode_req, in, 1, pulse: latch mode_sel as pending.
- scroll_en, in, 1, enable per-frame scroll (modes 0, 2).
- o_r, out, COLOR_W, red.
- o_g, out, COLOR_W, green.
- o_b, out, COLOR_W, blue.
- o_de, out, 1, video_on delayed to align with colour.
- mode_cur, out, 2, active mode.

Behaviour:
- Clock, reset and timing:
  - One clock; reset is synchronous and active-high on `rst` (`clk` rising edge).
  - Reset: o_r/o_g/o_b=0, o_de=0, mode_cur=0, pending=0; all counters, offsets and frame_cnt=0.
- Palette, index 0..7, each channel all-ones or zero: black, white, red, green, blue, cyan, magenta, yellow.
- H counter (hpix 0..BAR_W-1, hbar 0..NUM_BARS-1):
  - Advances on each video_on cycle; hpix wraps to 0 with hbar+1, and hbar wraps NUM_BARS-1→0.
  - Reloaded with (off_pix, off_bar) on video_on falling edge and on frame_start.
- V counter (vpix 0..BAR_H-1, vbar):
  - Advances once per line on video_on falling edge; same wrap rules.
  - Cleared on frame_start.
- Modes, via colour index:
  - 0: vertical bars, index = hbar.
  - 1: horizontal bars, index = vbar.
  - 2: checkerboard, white if hbar[0]^vbar[0], else black.
  - 3: solid, index = frame_cnt[FRAME_DIV+2:FRAME_DIV].
- frame_start actions:
  - frame_cnt+1 (wraps).
  - mode_cur←pending.
  - If mode changes: offsets←0.
  - Else if scroll_en and mode_cur∈{0,2}: off_pix+=SCROLL_STEP with carry into off_bar; both wrap.
- mode_req and frame_start in the same cycle: mode_sel is applied directly at that frame_start.
- mode_req mid-frame: held pending, never applied mid-frame.
- frame_start while video_on=1: still executed; counters reload; no output glitch beyond the pattern jump.
- Output: registered, latency 1 cycle from video_on; o_de=video_on delayed; colour forced 0 when the delayed video_on=0.
- Reset mid-line: outputs 0 on the next edge; pattern restarts at offset 0 / mode 0.

Optional Feature:
- Macro PATTERN_GRID_OVERLAY_EN.
- Defined: pixels with hpix==0 or vpix==0 are output as white in every mode except 3.
- Undefined: no overlay; the logic is absent.

Decomposition:
- Package pattern_gen_pkg holds:
  - mode constants MODE_VBAR/MODE_HBAR/MODE_CHECK/MODE_SOLID;
  - 3-bit palette index typedef;
  - palette lookup function expanding index to COLOR_W channels.
- Sub-module bar_counter holds pix/bar counters with load, advance and wrap.
  - Instantiated for H and V.
  - Also used as the offset accumulator, with step SCROLL_STEP.

Test Plan:
- Reset, mode 0, no scroll, 640-px line: px0-79 → 000, px80 → FFF one cycle after input, px160 → F00, px560-639 → FF0; o_de tracks video_on +1.
- Scroll, SCROLL_STEP=1: after 1 frame, px79 → FFF; after 80 frames, px0 → FFF; after 640 frames, pattern equals frame 0.
- mode_req=1 mid-frame with mode_sel=2: mode_cur stays 0 until the next frame_start, then becomes 2; line 0 px0 → 000, px80 → FFF; line 60 px0 → FFF.
- Mode 3, FRAME_DIV=5: frames 0-31 black, frame 32 white, frame 256 black again.
- mode_req coincident with frame_start, mode_sel=1: mode 1 active from that frame; all lines 0-59 → 000, lines 60-119 → FFF.
- rst asserted mid-line in mode 2 with scroll: next cycle outputs 0 and mode_cur=0; after release, px0 black, offsets 0.

Source files
------------

// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared types, mode encodings and the colour palette used
// by the VGA test-pattern generator and its bar counters.
package pattern_gen_pkg;

  // Runtime-selectable pattern modes
  typedef enum logic [1:0] {
    MODE_VBAR  = 2'd0,
    MODE_HBAR  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_SOLID = 2'd3
  } mode_t;

  // 3-bit palette index and bar index (at most eight bars)
  typedef logic [2:0] pal_idx_t;
  typedef logic [2:0] bar_idx_t;

  // One bit per channel; the top replicates each bit across COLOR_W
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_mask_t;

  localparam pal_idx_t PAL_BLACK = 3'd0;
  localparam pal_idx_t PAL_WHITE = 3'd1;

  // Expands a palette index into per-channel all-ones/zero flags:
  // black, white, red, green, blue, cyan, magenta, yellow
  function automatic rgb_mask_t palette_lookup(input pal_idx_t idx);
    rgb_mask_t rgb;
    case (idx)
      3'd0:    rgb = 3'b000;
      3'd1:    rgb = 3'b111;
      3'd2:    rgb = 3'b100;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b001;
      3'd5:    rgb = 3'b011;
      3'd6:    rgb = 3'b101;
      default: rgb = 3'b110;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/pattern_gen_bar_counter.sv
// bar_counter: two-level position counter (pixel within bar, bar index).
// The pixel part advances by STEP and carries into the bar index when it
// reaches PIX_MAX; the bar index wraps after BAR_MAX bars. A load overrides
// an advance. The next-state value is exported so a consumer can act on the
// value being written at this edge (used for the scroll offset).
module bar_counter
  import pattern_gen_pkg::*;
#(
  parameter int PIX_MAX = 80,
  parameter int BAR_MAX = 8,
  parameter int STEP    = 1,
  parameter int PIX_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PIX_W-1:0] load_pix,
  input  bar_idx_t         load_bar,
  input  logic             adv,
  output logic [PIX_W-1:0] pix,
  output bar_idx_t         bar,
  output logic [PIX_W-1:0] pix_nxt,
  output bar_idx_t         bar_nxt
);

  localparam logic [PIX_W:0]   STEP_X   = (PIX_W+1)'(STEP);
  localparam logic [PIX_W:0]   WRAP_X   = (PIX_W+1)'(PIX_MAX);
  localparam logic [PIX_W-1:0] WRAP_LO  = PIX_W'(PIX_MAX);
  localparam bar_idx_t         BAR_LAST = bar_idx_t'(BAR_MAX - 1);

  logic [PIX_W:0] sum;

  // Next position: load wins, otherwise step with single-subtract wrap
  always_comb begin
    sum     = {1'b0, pix} + STEP_X;
    pix_nxt = pix;
    bar_nxt = bar;
    if (load) begin
      pix_nxt = load_pix;
      bar_nxt = load_bar;
    end else if (adv) begin
      if (sum >= WRAP_X) begin
        pix_nxt = sum[PIX_W-1:0] - WRAP_LO;
        bar_nxt = (bar == BAR_LAST) ? '0 : bar + 3'd1;
      end else begin
        pix_nxt = sum[PIX_W-1:0];
      end
    end
  end

  // Position register
  always_ff @(posedge clk) begin
    if (rst) begin
      pix <= '0;
      bar <= '0;
    end else begin
      pix <= pix_nxt;
      bar <= bar_nxt;
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen: VGA test-pattern generator driven by video_on/frame_start.
// Four modes (vertical bars, horizontal bars, checkerboard, solid cycling
// colour), mode changes only at frame_start, optional per-frame horizontal
// scroll, and registered colour/DE outputs one cycle behind video_on.
// Optional build macro PATTERN_GRID_OVERLAY_EN draws a white grid on the
// first pixel column and first line of every bar (all modes except solid).
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int COLOR_W     = 4,
  parameter int BAR_W       = 80,
  parameter int BAR_H       = 60,
  parameter int NUM_BARS    = 8,
  parameter int SCROLL_STEP = 1,
  parameter int FRAME_DIV   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               video_on,
  input  logic               frame_start,
  input  logic [1:0]         mode_sel,
  input  logic               mode_req,
  input  logic               scroll_en,
  output logic [COLOR_W-1:0] o_r,
  output logic [COLOR_W-1:0] o_g,
  output logic [COLOR_W-1:0] o_b,
  output logic               o_de,
  output logic [1:0]         mode_cur
);

  localparam int HPIX_W = $clog2(BAR_W);
  localparam int VPIX_W = (BAR_H > 1) ? $clog2(BAR_H) : 1;
  localparam int FCNT_W = FRAME_DIV + 3;

  mode_t             mode_q, mode_d;
  mode_t             pending_q, pending_d;
  logic              mode_change;
  logic              scroll_adv;
  logic              line_end;
  logic [FCNT_W-1:0] frame_cnt;

  logic [HPIX_W-1:0] off_pix, off_pix_nxt;
  bar_idx_t          off_bar, off_bar_nxt;
  logic [HPIX_W-1:0] h_pix, h_pix_nxt, h_load_pix;
  bar_idx_t          h_bar, h_bar_nxt, h_load_bar;
  logic [VPIX_W-1:0] v_pix, v_pix_nxt;
  bar_idx_t          v_bar, v_bar_nxt;

  pal_idx_t          pix_idx;
  rgb_mask_t         pix_rgb;

  // o_de is video_on from the previous cycle, so it doubles as the
  // edge-detect history for the end of each active line
  assign line_end = o_de & ~video_on;
  assign mode_cur = mode_q;

  // Mode request bookkeeping and frame-start decisions; a request arriving
  // together with frame_start bypasses the pending register
  always_comb begin
    pending_d   = pending_q;
    mode_d      = mode_q;
    mode_change = 1'b0;
    scroll_adv  = 1'b0;
    if (mode_req) begin
      pending_d = mode_t'(mode_sel);
    end
    if (frame_start) begin
      mode_d      = mode_req ? mode_t'(mode_sel) : pending_q;
      mode_change = (mode_d != mode_q);
      scroll_adv  = !mode_change && scroll_en &&
                    ((mode_q == MODE_VBAR) || (mode_q == MODE_CHECK));
    end
  end

  // Mode, pending request and frame counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_VBAR;
      pending_q <= MODE_VBAR;
      frame_cnt <= '0;
    end else begin
      mode_q    <= mode_d;
      pending_q <= pending_d;
      if (frame_start) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
    end
  end

  // Scroll offset accumulator: cleared on a mode change, stepped per frame
  bar_counter #(
    .PIX_MAX (BAR_W),
    .BAR_MAX (NUM_BARS),
    .STEP    (SCROLL_STEP),
    .PIX_W   (HPIX_W)
  ) u_offset (
    .clk      (clk),
    .rst      (rst),
    .load     (mode_change),
    .load_pix ('0),
    .load_bar ('0),
    .adv      (scroll_adv),
    .pix      (off_pix),
    .bar      (off_bar),
    .pix_nxt  (off_pix_nxt),
    .bar_nxt  (off_bar_nxt)
  );

  // At frame_start the offset is being updated on the same edge, so the
  // horizontal reload takes the value being written rather than the old one
  assign h_load_pix = frame_start ? off_pix_nxt : off_pix;
  assign h_load_bar = frame_start ? off_bar_nxt : off_bar;

  // Horizontal position: reloaded at every line end and frame start
  bar_counter #(
    .PIX_MAX (BAR_W),
    .BAR_MAX (NUM_BARS),
    .STEP    (1),
    .PIX_W   (HPIX_W)
  ) u_hcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (frame_start | line_end),
    .load_pix (h_load_pix),
    .load_bar (h_load_bar),
    .adv      (video_on),
    .pix      (h_pix),
    .bar      (h_bar),
    .pix_nxt  (h_pix_nxt),
    .bar_nxt  (h_bar_nxt)
  );

  // Vertical position: one step per line, cleared at frame start
  bar_counter #(
    .PIX_MAX (BAR_H),
    .BAR_MAX (NUM_BARS),
    .STEP    (1),
    .PIX_W   (VPIX_W)
  ) u_vcnt (
    .clk      (clk),
    .rst      (rst),
    .load     (frame_start),
    .load_pix ('0),
    .load_bar ('0),
    .adv      (line_end),
    .pix      (v_pix),
    .bar      (v_bar),
    .pix_nxt  (v_pix_nxt),
    .bar_nxt  (v_bar_nxt)
  );

  // Colour index selection for the current pixel
  always_comb begin
    pix_idx = PAL_BLACK;
    case (mode_q)
      MODE_VBAR:  pix_idx = h_bar;
      MODE_HBAR:  pix_idx = v_bar;
      MODE_CHECK: pix_idx = (h_bar[0] ^ v_bar[0]) ? PAL_WHITE : PAL_BLACK;
      MODE_SOLID: pix_idx = frame_cnt[FRAME_DIV+2:FRAME_DIV];
      default:    pix_idx = PAL_BLACK;
    endcase
`ifdef PATTERN_GRID_OVERLAY_EN
    if ((mode_q != MODE_SOLID) && ((h_pix == '0) || (v_pix == '0))) begin
      pix_idx = PAL_WHITE;
    end
`endif
    pix_rgb = palette_lookup(pix_idx);
  end

`ifndef PATTERN_GRID_OVERLAY_EN
  // Pixel-within-bar positions only feed the grid overlay
  logic unused_grid;
  assign unused_grid = ^{h_pix, v_pix};
`endif

  // Counter next-state taps and low frame_cnt bits are not needed here
  logic unused_taps;
  assign unused_taps = ^{h_pix_nxt, h_bar_nxt, v_pix_nxt, v_bar_nxt, frame_cnt};

  // Registered outputs; colour is blanked whenever the pixel is not active
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r  <= '0;
      o_g  <= '0;
      o_b  <= '0;
      o_de <= 1'b0;
    end else begin
      o_de <= video_on;
      if (video_on) begin
        o_r <= {COLOR_W{pix_rgb.r}};
        o_g <= {COLOR_W{pix_rgb.g}};
        o_b <= {COLOR_W{pix_rgb.b}};
      end else begin
        o_r <= '0;
        o_g <= '0;
        o_b <= '0;
      end
    end
  end

endmodule
